// File: rtl/mapped_combiner_n.sv
// mapped_combiner_n: register-mapped N-channel operand combiner with per-channel
// input FIFOs, an output FIFO, optional interval gating and a saturating drop counter.
module mapped_combiner_n #(
  parameter int unsigned NCH   = 2,
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [2:0]    write_address,
  input  logic [DW-1:0] write_data,
  input  logic          write_en,
  output logic          write_rdy,
  input  logic [2:0]    read_address,
  input  logic          read_en,
  output logic [DW-1:0] read_data,
  output logic          read_rdy,
  output logic          fire
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [2:0] A_STATUS   = 3'd4;
  localparam logic [2:0] A_OUT      = 3'd5;
  localparam logic [2:0] A_CTRL     = 3'd6;
  localparam logic [2:0] A_INTERVAL = 3'd7;
  typedef logic [AW:0] ptr_t;

  logic [2:0]     ctrl;
  logic [DW-1:0]  interval, timer, drop_cnt;

  logic [NCH-1:0] in_empty, in_full, in_drop;
  logic [DW-1:0]  in_head [NCH];
  logic [DW-1:0]  f_or [NCH], f_and [NCH], f_xor [NCH], f_add [NCH], f_rd [NCH];

  logic [DW-1:0]  out_mem [DEPTH];
  ptr_t           out_wp, out_rp;
  logic           out_empty, out_full, out_pop;
  logic [DW-1:0]  out_head, result;
  logic [5:0]     status;
  logic           combine, wr_ctrl, wr_interval;

  assign write_rdy   = 1'b1;
  assign read_rdy    = 1'b1;
  assign wr_ctrl     = write_en && (write_address == A_CTRL);
  assign wr_interval = write_en && (write_address == A_INTERVAL);
  assign combine     = (&(~in_empty)) && !out_full && (!ctrl[2] || timer == interval);

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    localparam logic [2:0] ADDR = 3'(g);
    logic [DW-1:0] mem [DEPTH];
    ptr_t          wp, rp;
    logic          push, pop;
    logic [DW-1:0] rd_term;

    assign in_empty[g] = (wp == rp);
    assign in_full[g]  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign in_head[g]  = in_empty[g] ? '0 : mem[rp[AW-1:0]];
    assign push        = write_en && (write_address == ADDR);
    assign in_drop[g]  = push && in_full[g];
    // A combine and a read-pop in the same cycle remove a single entry.
    assign pop         = combine || (read_en && (read_address == ADDR) && !in_empty[g]);
    assign rd_term     = (read_address == ADDR) ? in_head[g] : '0;

    if (g == 0) begin : g_first
      assign f_or[g]  = in_head[g];
      assign f_and[g] = in_head[g];
      assign f_xor[g] = in_head[g];
      assign f_add[g] = in_head[g];
      assign f_rd[g]  = rd_term;
    end else begin : g_next
      assign f_or[g]  = f_or[g-1]  | in_head[g];
      assign f_and[g] = f_and[g-1] & in_head[g];
      assign f_xor[g] = f_xor[g-1] ^ in_head[g];
      assign f_add[g] = f_add[g-1] + in_head[g];
      assign f_rd[g]  = f_rd[g-1]  | rd_term;
    end

    always_ff @(posedge CLK) begin
      if (!RST_N) begin
        wp <= '0;
        rp <= '0;
      end else begin
        if (push && !in_full[g]) begin
          mem[wp[AW-1:0]] <= write_data;
          wp              <= wp + ptr_t'(1);
        end
        if (pop) rp <= rp + ptr_t'(1);
      end
    end
  end

  assign out_empty = (out_wp == out_rp);
  assign out_full  = (out_wp[AW] != out_rp[AW]) && (out_wp[AW-1:0] == out_rp[AW-1:0]);
  assign out_head  = out_empty ? '0 : out_mem[out_rp[AW-1:0]];
  assign out_pop   = read_en && (read_address == A_OUT) && !out_empty;

  always_comb begin
    result = f_or[NCH-1];
    case (ctrl[1:0])
      2'b01:   result = f_and[NCH-1];
      2'b10:   result = f_xor[NCH-1];
      2'b11:   result = f_add[NCH-1];
      default: result = f_or[NCH-1];
    endcase
  end

  always_comb begin
    status          = '0;
    status[0]       = !out_empty;
    status[1]       = out_full;
    status[2 +: NCH] = ~in_empty;
  end

  always_comb begin
    read_data = '0;
    case (read_address)
      A_STATUS:   read_data = DW'(status);
      A_OUT:      read_data = out_head;
      A_CTRL:     read_data = DW'(ctrl);
      A_INTERVAL: read_data = drop_cnt;
      default:    read_data = f_rd[NCH-1];
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      out_wp   <= '0;
      out_rp   <= '0;
      ctrl     <= '0;
      interval <= '0;
      timer    <= '0;
      drop_cnt <= '0;
      fire     <= 1'b0;
    end else begin
      if (combine) begin
        out_mem[out_wp[AW-1:0]] <= result;
        out_wp                  <= out_wp + ptr_t'(1);
      end
      if (out_pop) out_rp <= out_rp + ptr_t'(1);
      if (wr_ctrl) ctrl <= write_data[2:0];
      if (wr_interval) interval <= write_data;
      if (combine || wr_interval) timer <= '0;
      else if (timer < interval) timer <= timer + DW'(1);
      if ((|in_drop) && (drop_cnt != '1)) drop_cnt <= drop_cnt + DW'(1);
      fire <= combine;
    end
  end
endmodule
